// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder: FSM state encodings, the
// default operand width in bytes and the byte-counter width helper.
package add_pkg;

  localparam int ADD_NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } add_state_e;

  // Counter needs at least one bit even for a single-byte operand.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/add32_ser_add8.sv
// Existing 8-bit ripple adder used for one byte per cycle by add32_ser.
module add8 (
  output logic [7:0] SUM,
  output logic       cout,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin
);

  assign {cout, SUM} = {1'b0, A} + {1'b0, B} + {8'h00, cin};

endmodule

// File: rtl/add32_ser.sv
// Byte-serial adder: latches operands on start, adds one byte per cycle
// through a single add8, then pulses done with {cout,sum} = a+b+cin.
module add32_ser
  import add_pkg::*;
#(
  parameter int NBYTES = ADD_NBYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [8*NBYTES-1:0] sum,
  output logic              cout
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = cnt_width(NBYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  add_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [7:0]     byte_a_s;
  logic [7:0]     byte_b_s;
  logic [7:0]     byte_sum_s;
  logic           byte_co_s;

  // Byte lane selected by the counter; {cnt,000} is the bit offset of the lane.
  assign byte_a_s = a_q[{cnt_q, 3'b000} +: 8];
  assign byte_b_s = b_q[{cnt_q, 3'b000} +: 8];

  add8 u_add8 (
    .SUM  (byte_sum_s),
    .cout (byte_co_s),
    .A    (byte_a_s),
    .B    (byte_b_s),
    .cin  (carry_q)
  );

  // Next-state, datapath updates and registered status decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[{cnt_q, 3'b000} +: 8] = byte_sum_s;
        carry_d = byte_co_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          cout_d  = byte_co_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flops track the state we are entering, so they match a decode of state_q.
    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_add32_ser.sv
// Self-checking bench for add32_ser: directed vector table, random operations
// against a+b+cin arithmetic, and multi-cycle corner sequences.
module tb_add32_ser;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;

  int nchecks = 0;
  int nerr    = 0;

  add32_ser #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vc;
    logic [31:0] es;
    logic        ec;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete operation from an idle DUT, with latency/busy/hold checks.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                        input logic [31:0] es, input logic ec, input string nm);
    int edges;
    int busy_cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    busy_cyc = busy ? 1 : 0;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"}, 64'(edges), 64'd4);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_busy_cycles"}, 64'(busy_cyc), 64'd5);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
    chk({nm, "_sum_hold"}, 64'({cout, sum}), 64'({ec, es}));
  endtask

  vec_t vecs[6];
  logic [31:0] ha[30];
  logic [31:0] hb[30];
  logic        hc[30];

  initial begin
    logic [32:0] model;
    logic [31:0] ra, rb;
    logic        rc;
    int ndone;
    int last_done;
    int edges;
    int first_done_edge;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0; cin = 1'b0;
    #23;
    chk("reset_outputs", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run_op(ra, rb, rc, model[31:0], model[32], $sformatf("rnd%0d", i));
    end

    // Second start two cycles into RUN must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'h0102_0304; b = 32'h1020_3040; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 2; ndone = 0; first_done_edge = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done_edge < 0) begin
          first_done_edge = edges;
          chk("ignore_sum", 64'({cout, sum}), 64'({1'b0, 32'h1122_3345}));
        end
      end
    end
    chk("ignore_one_done", 64'(ndone), 64'd1);
    chk("ignore_latency", 64'(first_done_edge), 64'd4);

    // Reset while byte 2 is being processed.
    @(negedge clk);
    start = 1'b1; a = 32'h5555_5555; b = 32'h2222_2222; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun_reset_no_done", 64'(ndone), 64'd0);
    run_op(32'd100, 32'd200, 1'b1, 32'd301, 1'b0, "post_reset");

    // Start held high: accepted operands are those present at acceptance edges.
    ndone = 0; last_done = -1;
    for (int i = 0; i < 30; i++) begin
      ha[i] = $urandom; hb[i] = $urandom; hc[i] = 1'($urandom);
      start = (i < 20); a = ha[i]; b = hb[i]; cin = hc[i];
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (i >= 4) begin
          model = {1'b0, ha[i-4]} + {1'b0, hb[i-4]} + {32'd0, hc[i-4]};
          chk($sformatf("held_result_e%0d", i), 64'({cout, sum}), 64'(model));
        end else begin
          chk("held_early_done", 64'(i), 64'd4);
        end
        if (last_done >= 0)
          chk("held_spacing", 64'(i - last_done), 64'd6);
        else
          chk("held_first_done", 64'(i), 64'd4);
        last_done = i;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/add32_ser.md
ADD32_SER -- requirements
Module: add32_ser

Interface
REQ-001 Parameter NBYTES, default 4, operand width in bytes; W = 8*NBYTES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  W  operand A; sampled on accepted start.
REQ-006 b  input  W  operand B; sampled on accepted start.
REQ-007 cin  input  1  carry-in; sampled on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; sum and cout valid.
REQ-010 sum  output  W  result {cout,sum} = a+b+cin mod 2^(W+1).
REQ-011 cout  output  1  carry out of MSB byte.

Function
REQ-012 FSM states IDLE, RUN, DONE; encodings fixed in the shared package.
REQ-013 IDLE: on start=1, latch a, b, cin into operand/carry registers, clear byte counter, go to RUN.
REQ-014 IDLE with start=0: remain in IDLE; no register changes.
REQ-015 RUN: each cycle, byte adder computes a_byte[cnt]+b_byte[cnt]+carry_reg; 8-bit result is written to sum byte cnt, carry_reg takes byte carry-out, cnt increments.
REQ-016 RUN lasts exactly NBYTES cycles; on the edge processing byte NBYTES-1, go to DONE and load cout from the final carry.
REQ-017 Latency: start accepted at edge k -> done high for the cycle after edge k+NBYTES (4 cycles for default).
REQ-018 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-019 start is ignored in RUN and DONE; no queueing; latched operands are not disturbed by input changes.
REQ-020 Back-to-back: start held high continuously yields a new operation accepted in the first IDLE cycle after DONE (one op per NBYTES+2 cycles).
REQ-021 sum and cout hold their last completed values until the next operation writes them; sum bytes are updated progressively during RUN and are valid only when done=1.
REQ-022 done and busy are registered outputs (decoded from state register, no combinational path from inputs).
REQ-023 Counter wrap: cnt is ceil(log2(NBYTES)) bits; its wrap at NBYTES-1 coincides with the RUN->DONE transition.

Reset
REQ-024 rst_n low forces, asynchronously: state=IDLE, cnt=0, carry_reg=0, operand registers=0, sum=0, cout=0, busy=0, done=0.
REQ-025 Reset asserted mid-RUN or in DONE aborts the operation; no done pulse is produced for it.
REQ-026 After rst_n deasserts, the first rising edge may accept start.

Structure
REQ-027 Shared package add_pkg holds state encodings (IDLE, RUN, DONE) and default NBYTES.
REQ-028 The per-byte sum uses one instance of the existing 8-bit adder add8 (ports SUM, cout, A, B, cin), driven by the byte mux and carry_reg.
REQ-029 No other sub-modules; byte select and sum byte write are implemented locally.

Verification
REQ-030 Reset then a=0, b=0, cin=0, start pulse -> done after 4 cycles, sum=0x00000000, cout=0.
REQ-031 a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0, busy high for 5 cycles.
REQ-032 a=0xFFFFFFFF, b=0x00000000, cin=1 -> full carry ripple across bytes: sum=0x00000000, cout=1; a=b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
REQ-033 start pulsed again two cycles after acceptance with different operands -> ignored; result matches first operands; exactly one done pulse.
REQ-034 rst_n driven low during RUN byte 2 -> all outputs 0 immediately, no done; subsequent start a=100, b=200, cin=1 -> sum=301, cout=0.
REQ-035 start held high for 20 cycles -> done pulses every 6 cycles, each with correct sum for operands presented at acceptance.
